// File: rtl/mem_arbiter.sv
// Single-port unified-memory arbiter: loader > data > fetch, with a loader burst
// limiter so a waiting core port is served within LD_BURST_MAX cycles.
module mem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 17,
   parameter int LD_BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] rdata,
   output logic          core_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(LD_BURST_MAX + 1);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_LD   = 2'd3;

   logic [1:0]    owner_q, owner_d;
   logic [CW-1:0] ld_cnt_q, ld_cnt_d;
   logic          core_req;
   logic          ld_hold;

   always_comb begin
      core_req = if_req | d_req;
      // Loader yields one slot once it has won LD_BURST_MAX times in a row over a waiting core
      ld_hold  = core_req && (ld_cnt_q == CW'(LD_BURST_MAX));

      ld_gnt = ~reset & ld_req & ~ld_hold;
      d_gnt  = ~reset & d_req & ~ld_gnt;
      if_gnt = ~reset & if_req & ~ld_gnt & ~d_req;

      mem_en    = ld_gnt | d_gnt | if_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_d   = OWN_NONE;
      if (ld_gnt) begin
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
         if (!ld_we) owner_d = OWN_LD;
      end else if (d_gnt) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         if (!d_we) owner_d = OWN_D;
      end else if (if_gnt) begin
         mem_addr = if_addr;
         owner_d  = OWN_IF;
      end

      ld_cnt_d = '0;
      if (ld_gnt && core_req)
         ld_cnt_d = (ld_cnt_q == CW'(LD_BURST_MAX)) ? ld_cnt_q : ld_cnt_q + CW'(1);

      core_stall = ~reset & ((if_req & ~if_gnt) | (d_req & ~d_gnt));
   end

   // rvalid follows the registered owner, so a read granted just before reset still returns
   assign if_rvalid = (owner_q == OWN_IF);
   assign d_rvalid  = (owner_q == OWN_D);
   assign ld_rvalid = (owner_q == OWN_LD);
   assign rdata     = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         ld_cnt_q <= '0;
      end else begin
         owner_q  <= owner_d;
         ld_cnt_q <= ld_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM plus a per-cycle reference model of
// arbitration, burst fairness, read ownership and memory contents.
module tb_mem_arbiter;

   localparam int AW  = 8;
   localparam int DW  = 17;
   localparam int LBM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, d_req, d_we, ld_req, ld_we;
   logic [AW-1:0] if_addr, d_addr, ld_addr;
   logic [DW-1:0] d_wdata, ld_wdata;
   logic          if_gnt, d_gnt, ld_gnt, if_rvalid, d_rvalid, ld_rvalid;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic          core_stall, mem_en, mem_we;
   logic [AW-1:0] mem_addr;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] ram     [256];
   logic [DW-1:0] ref_mem [256];

   // reference model state: 0 none, 1 fetch, 2 data, 3 loader
   int            m_streak = 0;
   int            m_owner  = 0;
   logic [DW-1:0] m_data   = '0;
   int            m_win;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW), .LD_BURST_MAX(LBM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .rdata(rdata), .core_stall(core_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic idle();
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
   endtask

   // One cycle: settle, compare against the model, clock, advance the model.
   task automatic tick();
      logic          core_wants, exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic [2:0]    exp_gnt, exp_rv;
      #2;
      core_wants = if_req | d_req;
      if (reset)                                        m_win = 0;
      else if (ld_req && !(core_wants && m_streak >= LBM)) m_win = 3;
      else if (d_req)                                   m_win = 2;
      else if (if_req)                                  m_win = 1;
      else                                              m_win = 0;

      exp_we = 0; exp_addr = '0; exp_wdata = '0;
      case (m_win)
         3: begin exp_we = ld_we; exp_addr = ld_addr; exp_wdata = ld_wdata; end
         2: begin exp_we = d_we;  exp_addr = d_addr;  exp_wdata = d_wdata;  end
         1: begin exp_addr = if_addr; end
         default: ;
      endcase
      exp_gnt = (m_win == 0) ? 3'b000 : 3'(1 << (m_win - 1));
      exp_rv  = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));

      check("gnt{ld,d,if}", {29'd0, ld_gnt, d_gnt, if_gnt}, {29'd0, exp_gnt});
      check("core_stall", 32'(core_stall),
            32'(!reset && ((if_req && m_win != 1) || (d_req && m_win != 2))));
      check("mem_en", 32'(mem_en), 32'(m_win != 0));
      check("mem_we", 32'(mem_we), 32'(exp_we));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      check("rvalid{ld,d,if}", {29'd0, ld_rvalid, d_rvalid, if_rvalid}, {29'd0, exp_rv});
      if (m_owner != 0) check("rdata", 32'(rdata), 32'(m_data));

      @(posedge clk);
      if (reset) begin
         m_owner = 0; m_streak = 0;
      end else begin
         m_owner = (m_win != 0 && !exp_we) ? m_win : 0;
         if (m_owner != 0) m_data = ref_mem[exp_addr];
         if (m_win != 0 && exp_we) ref_mem[exp_addr] = exp_wdata;
         m_streak = (m_win == 3 && core_wants) ? ((m_streak < LBM) ? m_streak + 1 : LBM) : 0;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
      ram[8'h00] = 17'h1A001; ram[8'h01] = 17'h1A002; ram[8'h02] = 17'h1A003;
      ram[8'h40] = 17'h00055;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

      // reset with all requests high; first edge only initialises state
      idle();
      reset = 1; if_req = 1; d_req = 1; ld_req = 1; ld_addr = 8'h20;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) tick();
      reset = 0;
      tick();
      idle();
      tick();

      // fetch-only stream
      for (int i = 0; i < 3; i++) begin
         idle(); if_req = 1; if_addr = AW'(i);
         tick();
      end
      idle(); tick();

      // fetch/data conflict
      idle(); if_req = 1; if_addr = 8'h03; d_req = 1; d_addr = 8'h40;
      tick();
      idle(); if_req = 1; if_addr = 8'h03;
      tick();
      idle(); tick();

      // loader burst versus a held store
      for (int i = 0; i < 10; i++) begin
         idle();
         ld_req = 1; ld_we = 1; ld_addr = AW'(8'h90 + i); ld_wdata = DW'($urandom);
         if (i < 5) begin d_req = 1; d_we = 1; d_addr = 8'h80; d_wdata = 17'h1FFFF; end
         tick();
      end
      idle(); d_req = 1; d_addr = 8'h80; tick();
      idle(); tick();

      // write then read of the same address
      idle(); ld_req = 1; ld_we = 1; ld_addr = 8'h10; ld_wdata = 17'h12345; tick();
      idle(); if_req = 1; if_addr = 8'h10; tick();
      idle(); tick();

      // reset arriving right after a read grant
      idle(); d_req = 1; d_addr = 8'h41; tick();
      idle(); reset = 1; tick();
      reset = 0; tick();
      tick();

      // randomized traffic over a small address window to force collisions
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         ld_req   = ($urandom_range(0, 99) < 70);
         ld_we    = $urandom_range(0, 1) == 1;
         ld_addr  = AW'($urandom_range(0, 15));
         ld_wdata = DW'($urandom);
         d_req    = ($urandom_range(0, 99) < 50);
         d_we     = $urandom_range(0, 1) == 1;
         d_addr   = AW'($urandom_range(0, 15));
         d_wdata  = DW'($urandom);
         if_req   = ($urandom_range(0, 99) < 60);
         if_addr  = AW'($urandom_range(0, 15));
         tick();
      end
      reset = 0; idle(); tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
